// File: rtl/fpu_mac_avalon_master.sv
// fpu_mac_avalon_master
//   Avalon-MM master feeding a pipelined FPU MAC slave. It buffers 64-bit
//   operand words and writes each pair back to back (A word, then B word). It
//   honours waitrequest. After a pair whose B word carries the last flag, it
//   reads the accumulated result and strobes it out for one cycle.
//
// Ports
//   clk, reset    : rising-edge clock, asynchronous active-low reset
//   in_valid/in_data/in_last/in_ready : operand word stream (even = A, odd = B)
//   address/writedata/write/read/readdata/waitrequest : Avalon-MM master side
//   res_valid/res_data : one-cycle result strobe with captured readdata
//   busy          : FSM not idle or buffer not empty
//   job_count     : pairs completed since reset (wrapping)
module fpu_mac_avalon_master #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [2:0]  ADDR_A     = 3'd0,
    parameter logic [2:0]  ADDR_B     = 3'd1,
    parameter logic [2:0]  ADDR_RES   = 3'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [63:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic [2:0]  address,
    output logic [63:0] writedata,
    output logic        write,
    output logic        read,
    input  logic [63:0] readdata,
    input  logic        waitrequest,
    output logic        res_valid,
    output logic [63:0] res_data,
    output logic        busy,
    output logic [15:0] job_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_FILL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] PAIR_FILL = (AW+1)'(2);

    typedef enum logic [2:0] {
        st_idle,
        st_wr_a,
        st_wr_b,
        st_rd,
        st_rsp
    } state_t;

    state_t state, state_nxt;

    // Buffer entry: {last flag, data}. Pointers carry one extra wrap bit.
    logic [64:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, fill;
    logic [AW-1:0] rd_idx, rd_idx_n;
    logic          full, empty, push, pop, parity_b;

    logic [2:0]  address_nxt;
    logic [63:0] writedata_nxt, res_data_nxt;
    logic        write_nxt, read_nxt, res_valid_nxt, job_inc;

    assign fill     = wr_ptr - rd_ptr;
    assign full     = (fill == FULL_FILL);
    assign empty    = (fill == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign rd_idx   = rd_ptr[AW-1:0];
    assign rd_idx_n = rd_idx + AW'(1);
    assign busy     = (state != st_idle) || !empty;

    // The last flag is kept only on B words, so a stray in_last on an A word
    // never triggers a result read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_last && parity_b, in_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            parity_b <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + (AW+1)'(1);
                parity_b <= !parity_b;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= st_idle;
            address   <= '0;
            writedata <= '0;
            write     <= 1'b0;
            read      <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            job_count <= '0;
        end else begin
            state     <= state_nxt;
            address   <= address_nxt;
            writedata <= writedata_nxt;
            write     <= write_nxt;
            read      <= read_nxt;
            res_valid <= res_valid_nxt;
            res_data  <= res_data_nxt;
            if (job_inc) begin
                job_count <= job_count + 16'd1;
            end
        end
    end

    // Bus outputs are registered. Each state computes the values to present
    // in the next state, so the next-state logic also produces the next bus
    // values. Holding them (the defaults) keeps the bus stable under waitrequest.
    always_comb begin
        state_nxt     = state;
        address_nxt   = address;
        writedata_nxt = writedata;
        write_nxt     = write;
        read_nxt      = read;
        res_valid_nxt = 1'b0;
        res_data_nxt  = res_data;
        pop           = 1'b0;
        job_inc       = 1'b0;
        case (state)
            st_idle: begin
                // Both words must be buffered so that A and B issue back to back.
                if (fill >= PAIR_FILL) begin
                    state_nxt     = st_wr_a;
                    address_nxt   = ADDR_A;
                    writedata_nxt = mem[rd_idx][63:0];
                    write_nxt     = 1'b1;
                end
            end
            st_wr_a: begin
                if (!waitrequest) begin
                    pop           = 1'b1;
                    state_nxt     = st_wr_b;
                    address_nxt   = ADDR_B;
                    writedata_nxt = mem[rd_idx_n][63:0];
                end
            end
            st_wr_b: begin
                if (!waitrequest) begin
                    pop       = 1'b1;
                    job_inc   = 1'b1;
                    write_nxt = 1'b0;
                    if (mem[rd_idx][64]) begin
                        state_nxt   = st_rd;
                        address_nxt = ADDR_RES;
                        read_nxt    = 1'b1;
                    end else begin
                        state_nxt = st_idle;
                    end
                end
            end
            st_rd: begin
                if (!waitrequest) begin
                    read_nxt      = 1'b0;
                    res_data_nxt  = readdata;
                    res_valid_nxt = 1'b1;
                    state_nxt     = st_rsp;
                end
            end
            st_rsp: begin
                state_nxt = st_idle;
            end
            default: begin
                state_nxt = st_idle;
            end
        endcase
    end

endmodule

// File: tb/tb_fpu_mac_avalon_master.sv
// tb_fpu_mac_avalon_master
//   Directed bench for fpu_mac_avalon_master. It uses a table of operand pairs
//   and hand-written sequences for timing, stalls, backpressure and reset.
module tb_fpu_mac_avalon_master;

    localparam logic [2:0] ADDR_A   = 3'd0;
    localparam logic [2:0] ADDR_B   = 3'd1;
    localparam logic [2:0] ADDR_RES = 3'd1;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic [2:0]  address;
    logic [63:0] writedata;
    logic        write;
    logic        read;
    logic [63:0] readdata;
    logic        waitrequest;
    logic        res_valid;
    logic [63:0] res_data;
    logic        busy;
    logic [15:0] job_count;

    fpu_mac_avalon_master #(
        .FIFO_DEPTH (4),
        .ADDR_A     (ADDR_A),
        .ADDR_B     (ADDR_B),
        .ADDR_RES   (ADDR_RES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .address     (address),
        .writedata   (writedata),
        .write       (write),
        .read        (read),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .busy        (busy),
        .job_count   (job_count)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Slave-side monitor: logs completed transfers and result strobes.
    logic [66:0] wr_q [$];
    int unsigned rd_cnt   = 0;
    int unsigned res_cnt  = 0;
    int unsigned both_cnt = 0;

    always @(posedge clk) begin
        if (reset) begin
            if (write && !waitrequest) wr_q.push_back({address, writedata});
            if (read && !waitrequest)  rd_cnt++;
            if (read && write)         both_cnt++;
            if (res_valid)             res_cnt++;
        end
    end

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        a_last;
        logic        b_last;
        int unsigned exp_read;
        logic [15:0] exp_job;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge. Returns at the negedge after the word is accepted.
    task automatic push(input logic [63:0] d, input logic l);
        int unsigned t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("push_accept", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("idle_reached", 64'(busy), 64'd0);
    endtask

    task automatic wait_wr_b();
        int unsigned t = 0;
        while (!(write && address == ADDR_B) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("wr_b_reached", 64'(write && address == ADDR_B), 64'd1);
    endtask

    task automatic apply_row(input int unsigned i);
        int unsigned q0 = wr_q.size();
        int unsigned r0 = rd_cnt;
        int unsigned s0 = res_cnt;
        push(tbl[i].a, tbl[i].a_last);
        push(tbl[i].b, tbl[i].b_last);
        wait_idle();
        check("row_write_count", 64'(wr_q.size() - q0), 64'd2);
        if (wr_q.size() >= q0 + 2) begin
            check("row_a_xfer", 64'(wr_q[q0]),     64'({ADDR_A, tbl[i].a}));
            check("row_b_xfer", 64'(wr_q[q0 + 1]), 64'({ADDR_B, tbl[i].b}));
        end
        check("row_read_count", 64'(rd_cnt - r0),  64'(tbl[i].exp_read));
        check("row_res_count",  64'(res_cnt - s0), 64'(tbl[i].exp_read));
        check("row_job_count",  64'(job_count),    64'(tbl[i].exp_job));
    endtask

    initial begin
        logic [63:0] w [8];
        logic [63:0] sa, sb;
        int unsigned q0, r0;

        tbl[0] = '{64'h418e333340866666, 64'h421ce3a341280000, 1'b0, 1'b0, 0, 16'd1};
        tbl[1] = '{64'h3f800000c0000000, 64'h4040000040800000, 1'b0, 1'b0, 0, 16'd2};
        tbl[2] = '{64'hc1200000_3fc00000, 64'h42c80000_bf000000, 1'b0, 1'b0, 0, 16'd3};
        tbl[3] = '{64'h40490fdb_402df854, 64'hc0a00000_41100000, 1'b0, 1'b0, 0, 16'd4};
        tbl[4] = '{64'h3dcccccd_bdcccccd, 64'h447a0000_c47a0000, 1'b0, 1'b0, 0, 16'd5};
        tbl[5] = '{64'hc2f60000_41a80000, 64'h3e800000_c1500000, 1'b0, 1'b1, 1, 16'd6};
        tbl[6] = '{64'h11112222_33334444, 64'h55556666_77778888, 1'b1, 1'b0, 0, 16'd7};

        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        readdata = '0; waitrequest = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_write",     64'(write),     64'd0);
        check("rst_read",      64'(read),      64'd0);
        check("rst_address",   64'(address),   64'd0);
        check("rst_writedata", writedata,      64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data",  res_data,       64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_job_count", 64'(job_count), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'd1);

        // Single pair, cycle-exact timing.
        readdata = 64'h0000_0000_c1a2_b3c4;
        sa = 64'h418e333340866666;
        sb = 64'h421ce3a341280000;
        push(sa, 1'b0);
        push(sb, 1'b1);
        check("sp_n_write",       64'(write),     64'd0);
        @(negedge clk);
        check("sp_n1_write",      64'(write),     64'd1);
        check("sp_n1_address",    64'(address),   64'(ADDR_A));
        check("sp_n1_writedata",  writedata,      sa);
        check("sp_n1_busy",       64'(busy),      64'd1);
        @(negedge clk);
        check("sp_n2_write",      64'(write),     64'd1);
        check("sp_n2_address",    64'(address),   64'(ADDR_B));
        check("sp_n2_writedata",  writedata,      sb);
        @(negedge clk);
        check("sp_n3_write",      64'(write),     64'd0);
        check("sp_n3_read",       64'(read),      64'd1);
        check("sp_n3_address",    64'(address),   64'(ADDR_RES));
        check("sp_n3_job_count",  64'(job_count), 64'd1);
        @(negedge clk);
        check("sp_n4_read",       64'(read),      64'd0);
        check("sp_n4_res_valid",  64'(res_valid), 64'd1);
        check("sp_n4_res_data",   res_data,       64'h0000_0000_c1a2_b3c4);
        @(negedge clk);
        check("sp_n5_res_valid",  64'(res_valid), 64'd0);
        check("sp_n5_busy",       64'(busy),      64'd0);
        check("sp_write_count",   64'(wr_q.size()), 64'd2);
        check("sp_read_count",    64'(rd_cnt),      64'd1);

        // Waitrequest held high for 5 cycles during WR_B.
        sa = 64'h0123456789abcdef;
        sb = 64'hfedcba9876543210;
        q0 = wr_q.size();
        push(sa, 1'b0);
        push(sb, 1'b0);
        wait_wr_b();
        waitrequest = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_write",     64'(write),     64'd1);
            check("stall_address",   64'(address),   64'(ADDR_B));
            check("stall_writedata", writedata,      sb);
            check("stall_job_count", 64'(job_count), 64'd1);
        end
        check("stall_xfers_held", 64'(wr_q.size() - q0), 64'd1);
        waitrequest = 1'b0;
        @(negedge clk);
        check("stall_rel_write",     64'(write),     64'd0);
        check("stall_rel_job_count", 64'(job_count), 64'd2);
        check("stall_xfer_count",    64'(wr_q.size() - q0), 64'd2);
        if (wr_q.size() >= q0 + 2) begin
            check("stall_b_xfer", 64'(wr_q[q0 + 1]), 64'({ADDR_B, sb}));
        end

        // Six-pair accumulate, then in_last on an A word.
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("acc_job_after_rst", 64'(job_count), 64'd0);
        readdata = 64'h0000_0000_c33a_ba50;
        q0 = wr_q.size();
        r0 = rd_cnt;
        for (int unsigned i = 0; i < 6; i++) apply_row(i);
        check("acc_total_writes", 64'(wr_q.size() - q0), 64'd12);
        check("acc_total_reads",  64'(rd_cnt - r0),      64'd1);
        check("acc_result",       64'(res_data[31:0]),   64'hc33aba50);
        check("acc_job_count",    64'(job_count),        64'd6);
        apply_row(6);
        check("alast_res_kept",   64'(res_data[31:0]),   64'hc33aba50);

        // FIFO full / backpressure with waitrequest held high.
        for (int k = 0; k < 8; k++) w[k] = 64'hA5A5_0000_0000_0000 | 64'(k + 1);
        q0 = wr_q.size();
        r0 = rd_cnt;
        readdata = 64'h0000_0000_0bad_cafe;
        waitrequest = 1'b1;
        for (int k = 0; k < 4; k++) push(w[k], 1'b0);
        check("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_data  = w[4];
        in_last  = 1'b0;
        repeat (2) @(negedge clk);
        check("full_in_ready_held", 64'(in_ready), 64'd0);
        waitrequest = 1'b0;
        @(negedge clk);
        waitrequest = 1'b1;
        check("full_pop_frees_slot", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("full_one_slot_only", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        check("full_single_xfer", 64'(wr_q.size() - q0), 64'd1);
        waitrequest = 1'b0;
        push(w[5], 1'b0);
        push(w[6], 1'b0);
        push(w[7], 1'b1);
        wait_idle();
        check("full_xfer_count", 64'(wr_q.size() - q0), 64'd8);
        if (wr_q.size() >= q0 + 8) begin
            for (int k = 0; k < 8; k++) begin
                check("full_xfer_order", 64'(wr_q[q0 + k]),
                      64'({(k % 2 == 1) ? ADDR_B : ADDR_A, w[k]}));
            end
        end
        check("full_read_count", 64'(rd_cnt - r0), 64'd1);
        check("full_res_data",   res_data,         64'h0000_0000_0bad_cafe);
        check("full_job_count",  64'(job_count),   64'd11);

        // Reset asserted in the middle of WR_B.
        sa = 64'h1111_1111_2222_2222;
        sb = 64'h3333_3333_4444_4444;
        push(sa, 1'b0);
        push(sb, 1'b1);
        wait_wr_b();
        waitrequest = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_write",     64'(write),     64'd0);
        check("mid_rst_read",      64'(read),      64'd0);
        check("mid_rst_busy",      64'(busy),      64'd0);
        check("mid_rst_job_count", 64'(job_count), 64'd0);
        @(negedge clk);
        waitrequest = 1'b0;
        reset = 1'b1;
        wr_q.delete();
        r0 = rd_cnt;
        @(negedge clk);
        check("post_rst_write", 64'(write), 64'd0);
        readdata = 64'h5555_6666_7777_8888;
        sa = 64'hc0000000_40000000;
        sb = 64'h40400000_c0400000;
        push(sa, 1'b0);
        push(sb, 1'b1);
        wait_idle();
        check("post_rst_xfer_count", 64'(wr_q.size()), 64'd2);
        if (wr_q.size() >= 2) begin
            check("post_rst_a_xfer", 64'(wr_q[0]), 64'({ADDR_A, sa}));
            check("post_rst_b_xfer", 64'(wr_q[1]), 64'({ADDR_B, sb}));
        end
        check("post_rst_read_count", 64'(rd_cnt - r0), 64'd1);
        check("post_rst_res_data",   res_data,         64'h5555_6666_7777_8888);
        check("post_rst_job_count",  64'(job_count),   64'd1);
        check("never_read_and_write", 64'(both_cnt),   64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
